// File: rtl/csr_regfile_pkg.sv
// Shared definitions for the CSR file: CSR numbers, field positions, Ecodes,
// timer FSM state type and the masked-write helper.
package csr_regfile_pkg;

  localparam logic [13:0] CSR_CRMD   = 14'h000;
  localparam logic [13:0] CSR_PRMD   = 14'h001;
  localparam logic [13:0] CSR_ECFG   = 14'h004;
  localparam logic [13:0] CSR_ESTAT  = 14'h005;
  localparam logic [13:0] CSR_ERA    = 14'h006;
  localparam logic [13:0] CSR_BADV   = 14'h007;
  localparam logic [13:0] CSR_EENTRY = 14'h00C;
  localparam logic [13:0] CSR_SAVE0  = 14'h030;
  localparam logic [13:0] CSR_SAVE1  = 14'h031;
  localparam logic [13:0] CSR_SAVE2  = 14'h032;
  localparam logic [13:0] CSR_SAVE3  = 14'h033;
  localparam logic [13:0] CSR_TID    = 14'h040;
  localparam logic [13:0] CSR_TCFG   = 14'h041;
  localparam logic [13:0] CSR_TVAL   = 14'h042;
  localparam logic [13:0] CSR_TICLR  = 14'h044;

  localparam logic [5:0] ECODE_INT  = 6'h00;
  localparam logic [5:0] ECODE_ADEF = 6'h08;
  localparam logic [5:0] ECODE_ALE  = 6'h09;
  localparam logic [5:0] ECODE_SYS  = 6'h0B;

  localparam logic [8:0] CRMD_RESET = 9'h008;
  localparam int CRMD_IE          = 2;
  localparam int ESTAT_IS_TIMER   = 11;
  localparam int ESTAT_ECODE_LSB  = 16;
  localparam int ESTAT_ESUB_LSB   = 22;
  localparam logic [12:0] ECFG_LIE_WMASK = 13'h1BFF;
  localparam int TCFG_EN          = 0;
  localparam int TCFG_PERIODIC    = 1;

  typedef enum logic {
    TIMER_IDLE  = 1'b0,
    TIMER_COUNT = 1'b1
  } timer_state_t;

  function automatic logic [31:0] masked_write(input logic [31:0] old_v,
                                               input logic [31:0] wval,
                                               input logic [31:0] wmask);
    return (old_v & ~wmask) | (wval & wmask);
  endfunction

endpackage

// File: rtl/csr_regfile_timer.sv
// Stable counter (TID), timer config (TCFG) and countdown (TVAL) with its
// IDLE/COUNT FSM; timer_int_set pulses in the cycle TVAL reaches zero.
module csr_regfile_timer
  import csr_regfile_pkg::*;
#(
  parameter int          TIMER_N   = 32,
  parameter logic [31:0] TID_RESET = 32'h0
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic [13:0]  csr_num,
  input  logic         csr_we,
  input  logic [31:0]  csr_wvalue,
  input  logic [31:0]  csr_wmask,
  output logic [31:0]  tid,
  output logic [31:0]  tcfg,
  output logic [31:0]  tval,
  output logic         timer_int_set,
  output timer_state_t timer_state
);

  logic [TIMER_N-1:0] tval_q;
  logic [31:0]        tcfg_new;
  logic               tcfg_wr;
  logic               tid_wr;

  assign tcfg_wr       = csr_we && (csr_num == CSR_TCFG);
  assign tid_wr        = csr_we && (csr_num == CSR_TID);
  assign tcfg_new      = masked_write(tcfg, csr_wvalue, csr_wmask);
  assign timer_int_set = (timer_state == TIMER_COUNT) && (tval_q == '0);
  assign tval          = 32'(tval_q);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      tid         <= TID_RESET;
      tcfg        <= '0;
      tval_q      <= '0;
      timer_state <= TIMER_IDLE;
    end else begin
      tid <= tid_wr ? masked_write(tid, csr_wvalue, csr_wmask) : tid + 32'd1;
      // A software TCFG write overrides whatever the countdown would do this cycle.
      if (tcfg_wr) begin
        tcfg <= tcfg_new;
        if (tcfg_new[TCFG_EN]) begin
          tval_q      <= {tcfg_new[TIMER_N-1:2], 2'b00};
          timer_state <= TIMER_COUNT;
        end else begin
          timer_state <= TIMER_IDLE;
        end
      end else if (timer_state == TIMER_COUNT) begin
        if (timer_int_set) begin
          if (tcfg[TCFG_PERIODIC]) begin
            tval_q <= {tcfg[TIMER_N-1:2], 2'b00};
          end else begin
            tval_q      <= '1;
            timer_state <= TIMER_IDLE;
          end
        end else begin
          tval_q <= tval_q - 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/csr_regfile.sv
// LoongArch-subset CSR file: masked writes, exception/ertn state, interrupts.
// Timer CSRs (TID/TCFG/TVAL/TICLR) are present only when CSR_TIMER_EN is defined.
module csr_regfile
  import csr_regfile_pkg::*;
#(
  parameter int          TIMER_N   = 32,
  parameter logic [31:0] TID_RESET = 32'h0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [13:0] csr_rnum,
  output logic [31:0] csr_rvalue,
  input  logic [13:0] csr_num,
  input  logic        csr_we,
  input  logic [31:0] csr_wvalue,
  input  logic [31:0] csr_wmask,
  input  logic        wb_ex,
  input  logic [5:0]  wb_ecode,
  input  logic [8:0]  wb_esubcode,
  input  logic [31:0] wb_pc,
  input  logic [31:0] wb_vaddr,
  input  logic        ertn_flush,
  input  logic [7:0]  hw_int_in,
  input  logic        ipi_int_in,
  output logic [31:0] ex_entry,
  output logic [31:0] ertn_entry,
  output logic        has_int
);

  logic [8:0]  crmd;
  logic [2:0]  prmd;
  logic [12:0] ecfg_lie;
  logic [1:0]  is_sw;
  logic [7:0]  is_hw;
  logic        is_ipi;
  logic        is_timer;
  logic [5:0]  ecode;
  logic [8:0]  esubcode;
  logic [31:0] era;
  logic [31:0] badv;
  logic [25:0] eentry;
  logic [31:0] save [4];
  logic [12:0] estat_is;
  logic [31:0] estat;
  logic [12:0] lie_m;
  logic        we;
  logic        save_sel;

  // Exceptions and ertn squash any CSR write committing in the same cycle.
  assign we       = csr_we & ~wb_ex & ~ertn_flush;
  assign save_sel = (csr_num[13:2] == CSR_SAVE0[13:2]);
  assign lie_m    = csr_wmask[12:0] & ECFG_LIE_WMASK;

  assign estat_is   = {is_ipi, is_timer, 1'b0, is_hw, is_sw};
  assign estat      = {1'b0, esubcode, ecode, 3'b000, estat_is};
  assign has_int    = crmd[CRMD_IE] & |(estat_is & ecfg_lie);
  assign ex_entry   = {eentry, 6'b0};
  assign ertn_entry = era;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      crmd     <= CRMD_RESET;
      prmd     <= '0;
      ecfg_lie <= '0;
      is_sw    <= '0;
      is_hw    <= '0;
      is_ipi   <= 1'b0;
      ecode    <= '0;
      esubcode <= '0;
      era      <= '0;
      badv     <= '0;
      eentry   <= '0;
      for (int i = 0; i < 4; i++) save[i] <= '0;
    end else begin
      is_hw  <= hw_int_in;
      is_ipi <= ipi_int_in;
      if (wb_ex) begin
        prmd     <= crmd[2:0];
        crmd[2:0] <= 3'b000;
        ecode    <= wb_ecode;
        esubcode <= wb_esubcode;
        era      <= wb_pc;
        if (wb_ecode == ECODE_ADEF)     badv <= wb_pc;
        else if (wb_ecode == ECODE_ALE) badv <= wb_vaddr;
      end else if (ertn_flush) begin
        crmd[2:0] <= prmd;
      end else if (we) begin
        case (csr_num)
          CSR_CRMD:   crmd     <= (crmd & ~csr_wmask[8:0]) | (csr_wvalue[8:0] & csr_wmask[8:0]);
          CSR_PRMD:   prmd     <= (prmd & ~csr_wmask[2:0]) | (csr_wvalue[2:0] & csr_wmask[2:0]);
          CSR_ECFG:   ecfg_lie <= (ecfg_lie & ~lie_m) | (csr_wvalue[12:0] & lie_m);
          CSR_ESTAT:  is_sw    <= (is_sw & ~csr_wmask[1:0]) | (csr_wvalue[1:0] & csr_wmask[1:0]);
          CSR_ERA:    era      <= masked_write(era, csr_wvalue, csr_wmask);
          CSR_BADV:   badv     <= masked_write(badv, csr_wvalue, csr_wmask);
          CSR_EENTRY: eentry   <= (eentry & ~csr_wmask[31:6]) | (csr_wvalue[31:6] & csr_wmask[31:6]);
          default: begin
            if (save_sel) save[csr_num[1:0]] <= masked_write(save[csr_num[1:0]], csr_wvalue, csr_wmask);
          end
        endcase
      end
    end
  end

`ifdef CSR_TIMER_EN
  logic [31:0]  tid;
  logic [31:0]  tcfg;
  logic [31:0]  tval;
  logic         timer_int_set;
  logic         ticlr_clr;
  timer_state_t timer_state_unused;

  csr_regfile_timer #(
    .TIMER_N   (TIMER_N),
    .TID_RESET (TID_RESET)
  ) u_timer (
    .clk           (clk),
    .resetn        (resetn),
    .csr_num       (csr_num),
    .csr_we        (we),
    .csr_wvalue    (csr_wvalue),
    .csr_wmask     (csr_wmask),
    .tid           (tid),
    .tcfg          (tcfg),
    .tval          (tval),
    .timer_int_set (timer_int_set),
    .timer_state   (timer_state_unused)
  );

  assign ticlr_clr = we && (csr_num == CSR_TICLR) && csr_wvalue[0] && csr_wmask[0];

  // A timer fire beats a TICLR clear landing in the same cycle.
  always_ff @(posedge clk) begin
    if (!resetn)            is_timer <= 1'b0;
    else if (timer_int_set) is_timer <= 1'b1;
    else if (ticlr_clr)     is_timer <= 1'b0;
  end
`else
  logic unused_timer_cfg;
  assign unused_timer_cfg = ^{TID_RESET, TIMER_N};
  assign is_timer = 1'b0;
`endif

  always_comb begin
    csr_rvalue = '0;
    case (csr_rnum)
      CSR_CRMD:   csr_rvalue = {23'b0, crmd};
      CSR_PRMD:   csr_rvalue = {29'b0, prmd};
      CSR_ECFG:   csr_rvalue = {19'b0, ecfg_lie};
      CSR_ESTAT:  csr_rvalue = estat;
      CSR_ERA:    csr_rvalue = era;
      CSR_BADV:   csr_rvalue = badv;
      CSR_EENTRY: csr_rvalue = {eentry, 6'b0};
      CSR_SAVE0:  csr_rvalue = save[0];
      CSR_SAVE1:  csr_rvalue = save[1];
      CSR_SAVE2:  csr_rvalue = save[2];
      CSR_SAVE3:  csr_rvalue = save[3];
`ifdef CSR_TIMER_EN
      CSR_TID:    csr_rvalue = tid;
      CSR_TCFG:   csr_rvalue = tcfg;
      CSR_TVAL:   csr_rvalue = tval;
`endif
      default:    csr_rvalue = '0;
    endcase
  end

endmodule

// File: tb/tb_csr_regfile.sv
// Bench for csr_regfile: directed plan plus random traffic, each cycle's
// outputs predicted by a per-CSR writable-mask model and checked by a monitor.
module tb_csr_regfile;
  import csr_regfile_pkg::*;

  localparam int W = 97;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [13:0] csr_rnum = '0;
  logic [31:0] csr_rvalue;
  logic [13:0] csr_num = '0;
  logic        csr_we = 1'b0;
  logic [31:0] csr_wvalue = '0;
  logic [31:0] csr_wmask = '0;
  logic        wb_ex = 1'b0;
  logic [5:0]  wb_ecode = '0;
  logic [8:0]  wb_esubcode = '0;
  logic [31:0] wb_pc = '0;
  logic [31:0] wb_vaddr = '0;
  logic        ertn_flush = 1'b0;
  logic [7:0]  hw_int_in = '0;
  logic        ipi_int_in = 1'b0;
  logic [31:0] ex_entry;
  logic [31:0] ertn_entry;
  logic        has_int;

  always #5 clk = ~clk;

  csr_regfile dut (
    .clk (clk), .resetn (resetn),
    .csr_rnum (csr_rnum), .csr_rvalue (csr_rvalue),
    .csr_num (csr_num), .csr_we (csr_we), .csr_wvalue (csr_wvalue), .csr_wmask (csr_wmask),
    .wb_ex (wb_ex), .wb_ecode (wb_ecode), .wb_esubcode (wb_esubcode),
    .wb_pc (wb_pc), .wb_vaddr (wb_vaddr), .ertn_flush (ertn_flush),
    .hw_int_in (hw_int_in), .ipi_int_in (ipi_int_in),
    .ex_entry (ex_entry), .ertn_entry (ertn_entry), .has_int (has_int)
  );

  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_item;
  int checks = 0;
  int failures = 0;

  // Reference model: one 32-bit image per architectural CSR.
  logic [31:0] m_crmd, m_prmd, m_ecfg, m_estat, m_era, m_badv, m_eentry;
  logic [31:0] m_tid, m_tcfg, m_tval;
  logic [31:0] m_save [4];
  bit          m_run;

  logic [13:0] nums [18] = '{CSR_CRMD, CSR_PRMD, CSR_ECFG, CSR_ESTAT, CSR_ERA, CSR_BADV,
                             CSR_EENTRY, CSR_SAVE0, CSR_SAVE1, CSR_SAVE2, CSR_SAVE3,
                             CSR_TID, CSR_TCFG, CSR_TVAL, CSR_TICLR,
                             14'h002, 14'h043, 14'h3FFF};
  logic [5:0]  ecodes [5] = '{ECODE_ADEF, ECODE_ALE, ECODE_SYS, ECODE_INT, 6'h3F};

  function automatic logic [31:0] writable(input logic [13:0] num);
    case (num)
      CSR_CRMD:   return 32'h0000_01FF;
      CSR_PRMD:   return 32'h0000_0007;
      CSR_ECFG:   return 32'h0000_1BFF;
      CSR_ESTAT:  return 32'h0000_0003;
      CSR_EENTRY: return 32'hFFFF_FFC0;
      CSR_ERA, CSR_BADV, CSR_SAVE0, CSR_SAVE1, CSR_SAVE2, CSR_SAVE3: return 32'hFFFF_FFFF;
`ifdef CSR_TIMER_EN
      CSR_TID, CSR_TCFG: return 32'hFFFF_FFFF;
`endif
      default:    return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] model_read(input logic [13:0] num);
    case (num)
      CSR_CRMD:   return m_crmd;
      CSR_PRMD:   return m_prmd;
      CSR_ECFG:   return m_ecfg;
      CSR_ESTAT:  return m_estat;
      CSR_ERA:    return m_era;
      CSR_BADV:   return m_badv;
      CSR_EENTRY: return m_eentry;
      CSR_SAVE0:  return m_save[0];
      CSR_SAVE1:  return m_save[1];
      CSR_SAVE2:  return m_save[2];
      CSR_SAVE3:  return m_save[3];
`ifdef CSR_TIMER_EN
      CSR_TID:    return m_tid;
      CSR_TCFG:   return m_tcfg;
      CSR_TVAL:   return m_tval;
`endif
      default:    return 32'h0;
    endcase
  endfunction

  function automatic logic model_has_int();
    return m_crmd[CRMD_IE] & (|(m_estat[12:0] & m_ecfg[12:0]));
  endfunction

  task automatic model_reset();
    m_crmd = 32'h8; m_prmd = 0; m_ecfg = 0; m_estat = 0; m_era = 0; m_badv = 0;
    m_eentry = 0; m_tid = 32'h0; m_tcfg = 0; m_tval = 0; m_run = 0;
    for (int i = 0; i < 4; i++) m_save[i] = 0;
  endtask

  // Advances the model across one clock edge using the inputs currently driven.
  task automatic model_update();
    logic [31:0] n_crmd, n_prmd, n_ecfg, n_estat, n_era, n_badv, n_eentry;
    logic [31:0] n_tid, n_tcfg, n_tval, wm;
    logic [31:0] n_save [4];
    bit n_run, fire;
    n_crmd = m_crmd; n_prmd = m_prmd; n_ecfg = m_ecfg; n_estat = m_estat;
    n_era = m_era; n_badv = m_badv; n_eentry = m_eentry;
    n_tid = m_tid; n_tcfg = m_tcfg; n_tval = m_tval; n_run = m_run; fire = 0;
    for (int i = 0; i < 4; i++) n_save[i] = m_save[i];
`ifdef CSR_TIMER_EN
    n_tid = m_tid + 1;
    fire = m_run && (m_tval == 0);
    if (fire) begin
      if (m_tcfg[TCFG_PERIODIC]) n_tval = {m_tcfg[31:2], 2'b00};
      else begin n_tval = 32'hFFFF_FFFF; n_run = 0; end
    end else if (m_run) n_tval = m_tval - 1;
`endif
    wm = csr_wmask & writable(csr_num);
    if (wb_ex) begin
      n_prmd[2:0] = m_crmd[2:0];
      n_crmd[2:0] = 3'b000;
      n_estat[21:16] = wb_ecode;
      n_estat[30:22] = wb_esubcode;
      n_era = wb_pc;
      if (wb_ecode == 6'h08) n_badv = wb_pc;
      else if (wb_ecode == 6'h09) n_badv = wb_vaddr;
    end else if (ertn_flush) begin
      n_crmd[2:0] = m_prmd[2:0];
    end else if (csr_we) begin
      case (csr_num)
        CSR_CRMD:   n_crmd = (m_crmd & ~wm) | (csr_wvalue & wm);
        CSR_PRMD:   n_prmd = (m_prmd & ~wm) | (csr_wvalue & wm);
        CSR_ECFG:   n_ecfg = (m_ecfg & ~wm) | (csr_wvalue & wm);
        CSR_ESTAT:  n_estat = (m_estat & ~wm) | (csr_wvalue & wm);
        CSR_ERA:    n_era = (m_era & ~wm) | (csr_wvalue & wm);
        CSR_BADV:   n_badv = (m_badv & ~wm) | (csr_wvalue & wm);
        CSR_EENTRY: n_eentry = (m_eentry & ~wm) | (csr_wvalue & wm);
        CSR_SAVE0, CSR_SAVE1, CSR_SAVE2, CSR_SAVE3:
          n_save[csr_num - CSR_SAVE0] = (m_save[csr_num - CSR_SAVE0] & ~wm) | (csr_wvalue & wm);
`ifdef CSR_TIMER_EN
        CSR_TID:    n_tid = (m_tid & ~wm) | (csr_wvalue & wm);
        CSR_TCFG: begin
          n_tcfg = (m_tcfg & ~wm) | (csr_wvalue & wm);
          n_run = n_tcfg[TCFG_EN];
          n_tval = n_tcfg[TCFG_EN] ? {n_tcfg[31:2], 2'b00} : m_tval;
        end
        CSR_TICLR:  if (csr_wvalue[0] && csr_wmask[0]) n_estat[11] = 1'b0;
`endif
        default: ;
      endcase
    end
    n_estat[9:2] = hw_int_in;
    n_estat[12] = ipi_int_in;
    if (fire) n_estat[11] = 1'b1;
    m_crmd = n_crmd; m_prmd = n_prmd; m_ecfg = n_ecfg; m_estat = n_estat;
    m_era = n_era; m_badv = n_badv; m_eentry = n_eentry;
    m_tid = n_tid; m_tcfg = n_tcfg; m_tval = n_tval; m_run = n_run;
    for (int i = 0; i < 4; i++) m_save[i] = n_save[i];
  endtask

  // Queue this cycle's expected outputs, then cross the clock edge.
  task automatic tick(input bit use_const, input logic [31:0] cval);
    logic [31:0] rv;
    rv = use_const ? cval : model_read(csr_rnum);
    exp_q.push_back({rv, model_has_int(), m_eentry, m_era});
    @(posedge clk);
    model_update();
    #1;
    csr_we = 1'b0; wb_ex = 1'b0; ertn_flush = 1'b0;
  endtask

  task automatic wr(input logic [13:0] num, input logic [31:0] val, input logic [31:0] mask);
    csr_we = 1'b1; csr_num = num; csr_wvalue = val; csr_wmask = mask;
    tick(1'b0, 32'h0);
  endtask

  task automatic rd_const(input logic [13:0] num, input logic [31:0] val);
    csr_rnum = num;
    tick(1'b1, val);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_item = exp_q.pop_front();
      chk("csr_rvalue", csr_rvalue, exp_item[96:65]);
      chk("has_int", {31'b0, has_int}, {31'b0, exp_item[64]});
      chk("ex_entry", ex_entry, exp_item[63:32]);
      chk("ertn_entry", ertn_entry, exp_item[31:0]);
    end
  end

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;

    rd_const(CSR_CRMD, 32'h8);
    wr(CSR_EENTRY, 32'h1C008000, 32'hFFFF_FFFF);
    rd_const(CSR_EENTRY, 32'h1C008000);
    wr(CSR_EENTRY, 32'h12345678, 32'hFFFF_FFFF);
    rd_const(CSR_EENTRY, 32'h12345640);

    // Exception entry from PLV3/IE1, then return.
    wr(CSR_CRMD, 32'h7, 32'h7);
    rd_const(CSR_CRMD, 32'hF);
    wb_ex = 1'b1; wb_ecode = ECODE_SYS; wb_esubcode = '0; wb_pc = 32'h1C000100;
    csr_rnum = CSR_CRMD;
    tick(1'b1, 32'hF);
    rd_const(CSR_CRMD, 32'h8);
    rd_const(CSR_PRMD, 32'h7);
    rd_const(CSR_ERA, 32'h1C000100);
    rd_const(CSR_ESTAT, 32'h000B0000);
    ertn_flush = 1'b1;
    tick(1'b0, 32'h0);
    rd_const(CSR_CRMD, 32'hF);

    // ALE exception beats a same-cycle SAVE0 write.
    wb_ex = 1'b1; wb_ecode = ECODE_ALE; wb_pc = 32'h1C000200; wb_vaddr = 32'hA0000003;
    csr_we = 1'b1; csr_num = CSR_SAVE0; csr_wvalue = 32'hDEADBEEF; csr_wmask = 32'hFFFF_FFFF;
    tick(1'b0, 32'h0);
    rd_const(CSR_BADV, 32'hA0000003);
    rd_const(CSR_SAVE0, 32'h0);

`ifdef CSR_TIMER_EN
    wr(CSR_ECFG, 32'h800, 32'hFFFF_FFFF);
    wr(CSR_CRMD, 32'h4, 32'h4);
    wr(CSR_TCFG, 32'h9, 32'hFFFF_FFFF);
    for (int k = 1; k <= 12; k++) rd_const(CSR_ESTAT, (k >= 10) ? 32'h00090800 : 32'h00090000);
    rd_const(CSR_TVAL, 32'hFFFF_FFFF);
    wr(CSR_TICLR, 32'h1, 32'hFFFF_FFFF);
    rd_const(CSR_ESTAT, 32'h00090000);
`else
    wr(CSR_TCFG, 32'h9, 32'hFFFF_FFFF);
    rd_const(CSR_TCFG, 32'h0);
`endif

    // Hardware line 0 maps to IS[2].
    wr(CSR_ECFG, 32'h4, 32'hFFFF_FFFF);
    wr(CSR_CRMD, 32'h4, 32'h4);
    hw_int_in = 8'h01;
    csr_rnum = CSR_ESTAT;
    tick(1'b0, 32'h0);
    tick(1'b0, 32'h0);
    wr(CSR_CRMD, 32'h0, 32'h4);
    tick(1'b0, 32'h0);
    hw_int_in = 8'h00;

    for (int n = 0; n < 600; n++) begin
      csr_rnum = nums[$urandom_range(0, 17)];
      if ($urandom_range(0, 99) < 30) begin
        csr_we = 1'b1;
        csr_num = nums[$urandom_range(0, 17)];
        csr_wvalue = (csr_num == CSR_TCFG) ? (($urandom_range(0, 5) << 2) | $urandom_range(0, 3))
                                           : $urandom;
        csr_wmask = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF : $urandom;
      end
      if ($urandom_range(0, 99) < 4) begin
        wb_ex = 1'b1;
        wb_ecode = ecodes[$urandom_range(0, 4)];
        wb_esubcode = 9'($urandom);
        wb_pc = $urandom;
        wb_vaddr = $urandom;
      end
      if ($urandom_range(0, 99) < 4) ertn_flush = 1'b1;
      if ($urandom_range(0, 99) < 10) hw_int_in = 8'($urandom);
      if ($urandom_range(0, 99) < 10) ipi_int_in = 1'($urandom);
      tick(1'b0, 32'h0);
    end

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL exp_q_drain: got %0d left expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/csr_regfile.md
Name: csr_regfile

Overview:
- Control/status register file for the LoongArch-subset five-stage pipeline; the responder to the writeback stage's CSR-write and exception/ertn interface.
- Commits masked CSR writes.
- Records exception state (PRMD, ESTAT, ERA, BADV) on wb_ex and restores CRMD on ertn.
- Supplies ex_entry/ertn_entry to the fetch stage and a combinational read port to decode.
- Owns the stable timer and interrupt pending/enable logic, and raises has_int.

Parameters:
- TIMER_N, 32, timer counter width; TVAL and TCFG.InitVal span [TIMER_N-1:2].
- TID_RESET, 32'h0, reset value of TID.

Ports:
- clk  in  1  clock
- resetn  in  1  reset
- csr_rnum  in  14  read CSR number (decode stage)
- csr_rvalue  out  32  read data, combinational from csr_rnum
- csr_num  in  14  write CSR number (from WB)
- csr_we  in  1  write enable, already qualified by WB
- csr_wvalue  in  32  write data
- csr_wmask  in  32  per-bit write mask
- wb_ex  in  1  exception commit
- wb_ecode  in  6  Ecode
- wb_esubcode  in  9  EsubCode
- wb_pc  in  32  faulting PC
- wb_vaddr  in  32  faulting data address (ALE)
- ertn_flush  in  1  ertn commit
- hw_int_in  in  8  hardware interrupt lines
- ipi_int_in  in  1  inter-processor interrupt
- ex_entry  out  32  exception target = EENTRY
- ertn_entry  out  32  return target = ERA
- has_int  out  1  interrupt pending and enabled

Behaviour:
- Reset and clock: reset resetn, synchronous, active-low; clock clk.
- Reset values: CRMD=32'h8 (PLV=0, IE=0, DA=1). TID=TID_RESET. All other CSRs 0. All outputs are therefore 0 except ex_entry/ertn_entry=0 and has_int=0.
- CSR map (hex):
  - CRMD 0, PRMD 1, ECFG 4, ESTAT 5, ERA 6, BADV 7, EENTRY C
  - SAVE0-3 30-33
  - TID 40, TCFG 41, TVAL 42, TICLR 44
  - Unmapped numbers read 0 and ignore writes.
- Write rule: reg <= (reg & ~csr_wmask) | (csr_wvalue & csr_wmask), applied only to writable fields:
  - CRMD[8:0]
  - PRMD[2:0]
  - ECFG.LIE[9:0],[12:11]
  - ESTAT.IS[1:0]
  - EENTRY[31:6]
  - ERA, BADV, SAVEn, TID, TCFG full width
  - TVAL is read-only.
  - TICLR: writing bit0=1 clears ESTAT.IS[11]; TICLR always reads 0.
- Writes take effect the next cycle. No read bypass: a same-cycle read returns the old value.
- Priority per cycle: wb_ex > ertn_flush > csr_we. If a higher-priority event is present, the lower ones are ignored.
- On wb_ex:
  - PRMD.PPLV<=CRMD.PLV, PRMD.PIE<=CRMD.IE
  - CRMD.PLV<=0, CRMD.IE<=0
  - ESTAT.Ecode<=wb_ecode, ESTAT.EsubCode<=wb_esubcode
  - ERA<=wb_pc
  - BADV<=wb_pc if ecode=08 (ADEF); BADV<=wb_vaddr if ecode=09 (ALE); otherwise BADV holds.
- On ertn_flush: CRMD.PLV<=PRMD.PPLV, CRMD.IE<=PRMD.PIE.
- Interrupt sampling, every cycle: ESTAT.IS[9:2]<=hw_int_in, ESTAT.IS[12]<=ipi_int_in.
- has_int = CRMD.IE & |(ESTAT.IS[12:0] & ECFG.LIE[12:0]).
- ex_entry = EENTRY and ertn_entry = ERA, both combinational from the registers.

Optional Feature:
- Macro: CSR_TIMER_EN.
- Defined:
  - The timer FSM is present with states IDLE and COUNT.
  - IDLE -> COUNT: csr_we to TCFG with new En=1; TVAL<={InitVal,2'b00}.
  - COUNT: TVAL decrements by 1 each cycle.
  - When TVAL==0 (fire): ESTAT.IS[11]<=1. If Periodic=1, reload {InitVal,2'b00} and stay in COUNT. If Periodic=0, TVAL<=all-ones and go to IDLE.
  - A TCFG write with En=0 forces IDLE; TVAL holds.
  - A TCFG write in the same cycle as fire wins over the reload/stop action; IS[11] is still set.
  - A TICLR clear in the same cycle as fire loses (IS[11]=1).
  - TID is a free-running counter, incremented every cycle unless written.
- Undefined:
  - TID, TCFG, TVAL and TICLR are absent and read 0.
  - ESTAT.IS[11] is tied 0.

Decomposition:
- Shared package csr_defs.vh:
  - CSR number macros
  - field bit-position/width macros (CRMD_PLV, ESTAT_IS, ...)
  - Ecode constants (ECODE_ADEF=08, ECODE_ALE=09, ECODE_INT=00, ECODE_SYS=0B)
- Sub-module csr_timer holds TID/TCFG/TVAL and the FSM, and outputs timer_int_set. Instantiated only under CSR_TIMER_EN.

Test Plan:
- Reset -> csr_rvalue(CRMD)=32'h8, has_int=0, ex_entry=0.
- Write EENTRY 32'h1C008000 with mask FFFFFFFF -> read 32'h1C008000 next cycle. Write 32'h12345678 -> reads 32'h12345640 (low 6 bits not writable).
- CRMD=0x7 (PLV3, IE1), wb_ex with ecode 0B, wb_pc=32'h1C000100 -> CRMD=0x8, PRMD=0x7, ERA=1C000100, ESTAT[21:16]=0B. Then ertn_flush -> CRMD PLV/IE=3/1.
- Same cycle wb_ex(ecode 09, wb_vaddr=32'hA0000003) plus csr_we to SAVE0 -> BADV=A0000003, SAVE0 unchanged.
- CSR_TIMER_EN: ECFG.LIE[11]=1, CRMD.IE=1, TCFG={InitVal=2,Periodic=0,En=1} -> IS[11] and has_int rise 9 cycles later. TVAL=FFFFFFFF afterwards. TICLR write 1 clears IS[11].
- hw_int_in=8'h01 with LIE[2]=1 and IE=1 -> has_int=1 one cycle later. IE=0 -> has_int=0.
